// File: rtl/nco_signal_gen_if.sv
// Load handshake bundle for nco_signal_gen: tuning word, duty word, valid/ready.
interface nco_signal_gen_if #(
  parameter int ACC_W  = 32,
  parameter int DUTY_W = 8
);
  logic [ACC_W-1:0]  ftw_in;
  logic [DUTY_W-1:0] duty_in;
  logic              load_valid;
  logic              load_ready;

  modport master (
    output ftw_in,
    output duty_in,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  ftw_in,
    input  duty_in,
    input  load_valid,
    output load_ready
  );
endinterface

// File: rtl/nco_signal_gen.sv
// NCO square-wave source: phase accumulator, duty compare, boundary-aligned word loads.
// Optional NCO_SYNC_OUT_EN adds a one-cycle sync_out strobe per accumulator wrap.
module nco_signal_gen #(
  parameter int ACC_W  = 32,
  parameter int DUTY_W = 8,
  parameter int CNT_W  = 31,
  parameter int CLK_HZ = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  nco_signal_gen_if.slave  load,
  input  logic             enable,
  input  logic             clr_cnt,
  output logic             signal_out,
  output logic [CNT_W-1:0] edge_cnt,
`ifdef NCO_SYNC_OUT_EN
  output logic             sync_out,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [ACC_W-1:0]  ACC_ZERO  = {ACC_W{1'b0}};
  localparam logic [DUTY_W-1:0] DUTY_ZERO = {DUTY_W{1'b0}};

  // CLK_HZ only documents the intended rate; a non-positive value is a misconfiguration.
  if (CLK_HZ <= 0) begin : g_bad_clk_hz
  end

  state_t            state_r, state_nx_s;
  logic [ACC_W-1:0]  acc_r, acc_nx_s;
  logic [ACC_W-1:0]  ftw_active_r, ftw_active_nx_s;
  logic [ACC_W-1:0]  ftw_pend_r, ftw_pend_nx_s;
  logic [DUTY_W-1:0] duty_active_r, duty_active_nx_s;
  logic [DUTY_W-1:0] duty_pend_r, duty_pend_nx_s;
  logic              signal_out_r, signal_nx_s;
  logic [CNT_W-1:0]  edge_cnt_r, edge_cnt_nx_s;
  logic              load_ready_r;
  logic              busy_r;
  logic [ACC_W:0]    sum_s;
  logic [ACC_W-1:0]  acc_inc_s;
  logic              wrap_s;
  logic              below_duty_s;
  logic              xfer_s;
  logic              ftw_zero_s;

  assign sum_s        = {1'b0, acc_r} + {1'b0, ftw_active_r};
  assign wrap_s       = sum_s[ACC_W];
  assign acc_inc_s    = sum_s[ACC_W-1:0];
  assign below_duty_s = (acc_inc_s[ACC_W-1 -: DUTY_W] < duty_active_r);
  assign xfer_s       = load.load_valid && load_ready_r;
  assign ftw_zero_s   = (ftw_active_r == ACC_ZERO);

  // Next-state, datapath and edge-counter logic.
  always_comb begin
    state_nx_s       = state_r;
    acc_nx_s         = acc_inc_s;
    signal_nx_s      = below_duty_s;
    ftw_active_nx_s  = ftw_active_r;
    duty_active_nx_s = duty_active_r;
    ftw_pend_nx_s    = ftw_pend_r;
    duty_pend_nx_s   = duty_pend_r;
    edge_cnt_nx_s    = edge_cnt_r;

    case (state_r)
      IDLE: begin
        acc_nx_s    = ACC_ZERO;
        signal_nx_s = 1'b0;
        if (xfer_s) begin
          ftw_active_nx_s  = load.ftw_in;
          duty_active_nx_s = load.duty_in;
        end else begin
          ftw_active_nx_s  = ftw_active_r;
          duty_active_nx_s = duty_active_r;
        end
        // Entry decision uses the words already active, not a same-cycle load.
        if (enable && !ftw_zero_s) begin
          state_nx_s  = RUN;
          signal_nx_s = (duty_active_r != DUTY_ZERO);
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (xfer_s) begin
          state_nx_s     = PEND;
          ftw_pend_nx_s  = load.ftw_in;
          duty_pend_nx_s = load.duty_in;
        end else if (!enable) begin
          state_nx_s = STOP;
        end else begin
          state_nx_s = RUN;
        end
      end
      PEND: begin
        // A zero tuning word never wraps, so the swap happens immediately instead.
        if (wrap_s || ftw_zero_s) begin
          ftw_active_nx_s  = ftw_pend_r;
          duty_active_nx_s = duty_pend_r;
          if (enable) begin
            state_nx_s = RUN;
          end else begin
            state_nx_s  = IDLE;
            acc_nx_s    = ACC_ZERO;
            signal_nx_s = 1'b0;
          end
        end else begin
          state_nx_s = PEND;
        end
      end
      STOP: begin
        if (xfer_s) begin
          state_nx_s     = PEND;
          ftw_pend_nx_s  = load.ftw_in;
          duty_pend_nx_s = load.duty_in;
        end else if (enable) begin
          state_nx_s = RUN;
        end else if (wrap_s || ftw_zero_s) begin
          state_nx_s  = IDLE;
          acc_nx_s    = ACC_ZERO;
          signal_nx_s = 1'b0;
        end else begin
          state_nx_s = STOP;
        end
      end
      default: begin
        state_nx_s  = IDLE;
        acc_nx_s    = ACC_ZERO;
        signal_nx_s = 1'b0;
      end
    endcase

    if (clr_cnt) begin
      edge_cnt_nx_s = {CNT_W{1'b0}};
    end else if (signal_nx_s && !signal_out_r && (edge_cnt_r != CNT_MAX)) begin
      edge_cnt_nx_s = edge_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      edge_cnt_nx_s = edge_cnt_r;
    end
  end

  // State, datapath and registered-output updates; reset drops any pending load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      acc_r         <= ACC_ZERO;
      ftw_active_r  <= ACC_ZERO;
      ftw_pend_r    <= ACC_ZERO;
      duty_active_r <= DUTY_ZERO;
      duty_pend_r   <= DUTY_ZERO;
      signal_out_r  <= 1'b0;
      edge_cnt_r    <= {CNT_W{1'b0}};
      load_ready_r  <= 1'b1;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      acc_r         <= acc_nx_s;
      ftw_active_r  <= ftw_active_nx_s;
      ftw_pend_r    <= ftw_pend_nx_s;
      duty_active_r <= duty_active_nx_s;
      duty_pend_r   <= duty_pend_nx_s;
      signal_out_r  <= signal_nx_s;
      edge_cnt_r    <= edge_cnt_nx_s;
      load_ready_r  <= (state_nx_s != PEND);
      busy_r        <= (state_nx_s != IDLE);
    end
  end

`ifdef NCO_SYNC_OUT_EN
  logic sync_r;

  // Period marker strobe, coincident with the rising edge that follows a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 1'b0;
    end else begin
      sync_r <= (state_r != IDLE) && wrap_s;
    end
  end

  assign sync_out = sync_r;
`endif

  assign load.load_ready = load_ready_r;
  assign signal_out      = signal_out_r;
  assign edge_cnt        = edge_cnt_r;
  assign busy            = busy_r;

endmodule

// File: tb/tb_nco_signal_gen.sv
// Scoreboard bench for nco_signal_gen: expected waveform queued per cycle, checked after each edge.
module tb_nco_signal_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clr_cnt;
  logic        signal_out;
  logic [30:0] edge_cnt;
  logic        busy;
`ifdef NCO_SYNC_OUT_EN
  logic        sync_out;
  logic        s_sync_out;
`endif

  logic        s_enable;
  logic        s_clr_cnt;
  logic        s_signal_out;
  logic [2:0]  s_edge_cnt;
  logic        s_busy;

  nco_signal_gen_if #(.ACC_W(32), .DUTY_W(8)) lif ();
  nco_signal_gen_if #(.ACC_W(32), .DUTY_W(8)) sif ();

  nco_signal_gen dut (
    .clk        (clk),
    .rst        (rst),
    .load       (lif),
    .enable     (enable),
    .clr_cnt    (clr_cnt),
    .signal_out (signal_out),
    .edge_cnt   (edge_cnt),
`ifdef NCO_SYNC_OUT_EN
    .sync_out   (sync_out),
`endif
    .busy       (busy)
  );

  // Narrow-counter instance so saturation is reachable in a short run.
  nco_signal_gen #(.CNT_W(3)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .load       (sif),
    .enable     (s_enable),
    .clr_cnt    (s_clr_cnt),
    .signal_out (s_signal_out),
    .edge_cnt   (s_edge_cnt),
`ifdef NCO_SYNC_OUT_EN
    .sync_out   (s_sync_out),
`endif
    .busy       (s_busy)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic sig;
    logic clr;
    logic rst;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic        mon_prev = 1'b0;
  logic [30:0] mon_cnt  = 31'd0;
  int          n_checks = 0;
  int          n_fails  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Queue the expected signal_out for the coming edge, then advance one cycle.
  task automatic step(input logic e);
    exp_t t;
    t.sig = e;
    t.clr = clr_cnt;
    t.rst = rst;
    sb_q.push_back(t);
    @(negedge clk);
  endtask

  task automatic drive_load(input logic [31:0] ftw, input logic [7:0] duty);
    lif.ftw_in     = ftw;
    lif.duty_in    = duty;
    lif.load_valid = 1'b1;
  endtask

  // Monitor: after each edge pop one expectation and derive the expected edge count.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        if (mon_e.rst) begin
          mon_cnt  = 31'd0;
          mon_prev = 1'b0;
        end else begin
          if (mon_e.clr) begin
            mon_cnt = 31'd0;
          end else if (mon_e.sig && !mon_prev && (mon_cnt != 31'h7FFF_FFFF)) begin
            mon_cnt = mon_cnt + 31'd1;
          end
          mon_prev = mon_e.sig;
        end
        check_eq("signal_out", 64'(signal_out), 64'(mon_e.sig));
        check_eq("edge_cnt", 64'(edge_cnt), 64'(mon_cnt));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    enable         = 1'b0;
    clr_cnt        = 1'b0;
    lif.ftw_in     = 32'h0;
    lif.duty_in    = 8'h0;
    lif.load_valid = 1'b0;
    s_enable       = 1'b0;
    s_clr_cnt      = 1'b0;
    sif.ftw_in     = 32'h0;
    sif.duty_in    = 8'h0;
    sif.load_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_signal_out", 64'(signal_out), 64'd0);
    check_eq("rst_edge_cnt", 64'(edge_cnt), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_load_ready", 64'(lif.load_ready), 64'd1);
    rst = 1'b0;

    // Quarter-rate, 50% duty: period 4, high 2.
    drive_load(32'h4000_0000, 8'h80);
    step(1'b0);
    lif.load_valid = 1'b0;
    check_eq("idle_busy", 64'(busy), 64'd0);
    enable = 1'b1;
    for (int k = 0; k < 400; k++) step(k % 4 < 2);
    check_eq("edge_cnt_400", 64'(edge_cnt), 64'd100);
    check_eq("run_busy", 64'(busy), 64'd1);

    // Mid-period reload to eighth-rate: old period completes first.
    step(1'b1);
    step(1'b1);
    drive_load(32'h2000_0000, 8'h80);
    step(1'b0);
    lif.load_valid = 1'b0;
    check_eq("pend_ready_a", 64'(lif.load_ready), 64'd0);
    step(1'b0);
    check_eq("pend_ready_b", 64'(lif.load_ready), 64'd0);
    step(1'b1);
    check_eq("pend_ready_done", 64'(lif.load_ready), 64'd1);
    for (int j = 1; j <= 16; j++) step(j % 8 < 4);

    // Drop enable just after a rising edge: period completes, then idle.
    enable = 1'b0;
    for (int j = 17; j <= 23; j++) step(j % 8 < 4);
    check_eq("stop_busy", 64'(busy), 64'd1);
    step(1'b0);
    check_eq("stop_idle_busy", 64'(busy), 64'd0);
    step(1'b0);
    enable = 1'b1;
    step(1'b1);
    step(1'b1);
    enable = 1'b0;
    step(1'b1);
    enable = 1'b1;
    step(1'b1);
    check_eq("stop_rerun_busy", 64'(busy), 64'd1);
    for (int p = 4; p <= 16; p++) step(p % 8 < 4);
    enable = 1'b0;
    for (int p = 17; p <= 23; p++) step(p % 8 < 4);
    step(1'b0);
    check_eq("stop2_idle_busy", 64'(busy), 64'd0);

    // Zero duty at 1/16 rate: no output, no edges.
    drive_load(32'h1000_0000, 8'h00);
    step(1'b0);
    lif.load_valid = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 258; i++) step(1'b0);
    drive_load(32'h1000_0000, 8'hFF);
    step(1'b0);
    lif.load_valid = 1'b0;
    check_eq("duty_pend_ready", 64'(lif.load_ready), 64'd0);
    for (int i = 259; i < 272; i++) step(1'b0);
    step(1'b0);
    check_eq("duty_swap_ready", 64'(lif.load_ready), 64'd1);
    for (int i = 273; i <= 288; i++) step(1'b1);

    // Zero tuning word freezes the phase; a later load applies on the next edge.
    drive_load(32'h0000_0000, 8'h80);
    step(1'b1);
    lif.load_valid = 1'b0;
    for (int i = 290; i <= 306; i++) step(1'b1);
    drive_load(32'h4000_0000, 8'h80);
    step(1'b1);
    lif.load_valid = 1'b0;
    check_eq("zftw_pend_ready", 64'(lif.load_ready), 64'd0);
    step(1'b1);
    check_eq("zftw_exit_ready", 64'(lif.load_ready), 64'd1);
    check_eq("zftw_exit_busy", 64'(busy), 64'd1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    clr_cnt = 1'b1;
    step(1'b1);
    clr_cnt = 1'b0;
    check_eq("clr_vs_edge", 64'(edge_cnt), 64'd0);

    // Reset while a load is pending: everything returns to reset, word dropped.
    step(1'b1);
    drive_load(32'h2000_0000, 8'h40);
    step(1'b0);
    lif.load_valid = 1'b0;
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    check_eq("pend_rst_busy", 64'(busy), 64'd0);
    check_eq("pend_rst_ready", 64'(lif.load_ready), 64'd1);
    check_eq("pend_rst_cnt", 64'(edge_cnt), 64'd0);
    repeat (6) step(1'b0);
    check_eq("pend_rst_stay_idle", 64'(busy), 64'd0);
    enable = 1'b0;
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

    // Saturation on the 3-bit counter instance.
    sif.ftw_in     = 32'h4000_0000;
    sif.duty_in    = 8'h80;
    sif.load_valid = 1'b1;
    @(negedge clk);
    sif.load_valid = 1'b0;
    s_enable       = 1'b1;
    repeat (9) @(negedge clk);
    check_eq("sat_cnt_3", 64'(s_edge_cnt), 64'd3);
    repeat (40) @(negedge clk);
    check_eq("sat_hold_max", 64'(s_edge_cnt), 64'd7);
    check_eq("sat_busy", 64'(s_busy), 64'd1);
    s_clr_cnt = 1'b1;
    @(negedge clk);
    s_clr_cnt = 1'b0;
    check_eq("sat_clr", 64'(s_edge_cnt), 64'd0);
    s_enable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
